sisc_ctrl_unit: RTL and testbench

//  Parametrised multi-cycle control FSM for the SISC datapath. Sequences

---
 rtl/sisc_pkg.sv | 36 +++
 rtl/sisc_mem_wait.sv | 30 +++
 rtl/sisc_ctrl_unit.sv | 176 +++++++++++++++++
 tb/tb_sisc_ctrl_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control path: FSM states, opcodes and ALU control codes.
package sisc_pkg;

    localparam int unsigned OPC_W = 4;

    typedef enum logic [2:0] {
        ST_START1    = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    // Opcodes live in the low four bits; HLT is all-ones at the full opcode width.
    localparam logic [OPC_W-1:0] OPC_NOOP = 4'h0;
    localparam logic [OPC_W-1:0] OPC_LOD  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_STR  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_SWP  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_BRA  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_BRR  = 4'h5;
    localparam logic [OPC_W-1:0] OPC_BNE  = 4'h6;
    localparam logic [OPC_W-1:0] OPC_BNR  = 4'h7;
    localparam logic [OPC_W-1:0] OPC_ALU  = 4'h8;
    localparam logic [OPC_W-1:0] OPC_HLT  = 4'hF;

    // ALU control encodings, zero-extended to the configured alu_op width.
    localparam logic [1:0] ALU_RR   = 2'd0;
    localparam logic [1:0] ALU_IMM  = 2'd1;
    localparam logic [1:0] ALU_IDLE = 2'd2;

    // Addressing-mode value that selects the immediate ALU form.
    localparam int unsigned AM_IMM_DEFAULT = 8;

endpackage

// File: rtl/sisc_mem_wait.sv
// Memory handshake wait counter with timeout detection.
module sisc_mem_wait #(
    parameter int unsigned MEM_TMO = 15
) (
    input  logic clk,
    input  logic rst_f,
    input  logic clear,
    input  logic inc,
    output logic tmo_c
);

    localparam int unsigned CW = $clog2(MEM_TMO + 1);

    logic [CW-1:0] cnt;

    // Count unanswered request cycles; saturate at the limit, clear on phase entry.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(MEM_TMO))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Timeout fires on the cycle whose increment would reach the limit.
    assign tmo_c = inc && (cnt == CW'(MEM_TMO - 1));

endmodule

// File: rtl/sisc_ctrl_unit.sv
// Multi-cycle SISC control FSM: fetch/decode/execute/mem/writeback with
// memory timeout, branch evaluation, sticky halt and a retired counter.
module sisc_ctrl_unit
    import sisc_pkg::*;
#(
    parameter int unsigned OP_W     = 4,
    parameter int unsigned FLAG_W   = 4,
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MEM_TMO  = 15,
    parameter int unsigned AM_IMM   = AM_IMM_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FLAG_W-1:0]   mm,
    input  logic [FLAG_W-1:0]   stat,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mm_we,
    output logic                ir_load,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                br_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                rf_we,
    output logic                wb_sel,
    output logic                halted,
    output logic                bus_err,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [OP_W-1:0]     OP_HLT   = {OP_W{1'b1}};
    localparam logic [FLAG_W-1:0]   MM_IMM   = FLAG_W'(AM_IMM);
    localparam logic [ALU_OP_W-1:0] AO_IDLE  = ALU_OP_W'(ALU_IDLE);
    localparam logic [ALU_OP_W-1:0] AO_IMM   = ALU_OP_W'(ALU_IMM);
    localparam logic [ALU_OP_W-1:0] AO_RR    = ALU_OP_W'(ALU_RR);

    state_e state;
    state_e state_nxt;

    logic op_lod, op_str, op_swp, op_alu, op_hlt;
    logic op_bra, op_brr, op_bne, op_bnr;
    logic br_hit, br_taken, br_rel;
    logic wait_clear, wait_inc, wait_tmo;

    // Opcode decode; anything unmatched behaves as NOOP.
    assign op_lod = (opcode == OP_W'(OPC_LOD));
    assign op_str = (opcode == OP_W'(OPC_STR));
    assign op_swp = (opcode == OP_W'(OPC_SWP));
    assign op_alu = (opcode == OP_W'(OPC_ALU));
    assign op_bra = (opcode == OP_W'(OPC_BRA));
    assign op_brr = (opcode == OP_W'(OPC_BRR));
    assign op_bne = (opcode == OP_W'(OPC_BNE));
    assign op_bnr = (opcode == OP_W'(OPC_BNR));
    assign op_hlt = (opcode == OP_HLT);

    // Branch condition: masked status non-zero for BRA/BRR, zero for BNE/BNR.
    assign br_hit   = |(stat & mm);
    assign br_taken = ((op_bra || op_brr) && br_hit) || ((op_bne || op_bnr) && !br_hit);
    assign br_rel   = op_brr || op_bnr;

    // Memory request is kept outside the FSM block so the timeout path has no comb loop.
    assign mem_req = (state == ST_FETCH) || ((state == ST_MEM) && (op_lod || op_str));
    assign mm_we   = (state == ST_MEM) && op_str;

    assign wait_inc   = mem_req && !mem_ack;
    assign wait_clear = (state_nxt != state) &&
                        ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM));

    sisc_mem_wait #(
        .MEM_TMO (MEM_TMO)
    ) u_mem_wait (
        .clk   (clk),
        .rst_f (rst_f),
        .clear (wait_clear),
        .inc   (wait_inc),
        .tmo_c (wait_tmo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= ST_START1;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky status flags and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            halted  <= 1'b0;
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            if (state_nxt == ST_HALT) begin
                halted <= 1'b1;
            end
            if (wait_tmo) begin
                bus_err <= 1'b1;
            end
            if (state == ST_WRITEBACK) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        br_sel    = 1'b0;
        alu_op    = AO_IDLE;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;

        case (state)
            ST_START1: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_load   = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (wait_tmo) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (op_hlt) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_EXECUTE;
                    if (br_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        br_sel   = br_rel;
                    end
                end
            end
            ST_EXECUTE: begin
                if (op_alu) begin
                    alu_op = (mm == MM_IMM) ? AO_IMM : AO_RR;
                end
                state_nxt = ST_MEM;
            end
            ST_MEM: begin
                if (op_lod || op_str) begin
                    if (mem_ack) begin
                        state_nxt = ST_WRITEBACK;
                    end else if (wait_tmo) begin
                        state_nxt = ST_HALT;
                    end
                end else begin
                    state_nxt = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                rf_we     = op_alu || op_lod || op_swp;
                wb_sel    = op_lod;
                state_nxt = ST_START1;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_START1;
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_unit.sv
// Directed scoreboard bench for sisc_ctrl_unit.
module tb_sisc_ctrl_unit;
    import sisc_pkg::*;

    localparam int unsigned MEM_TMO = 15;

    typedef struct packed {
        logic       mem_req;
        logic       mm_we;
        logic       ir_load;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic [1:0] alu_op;
        logic       rf_we;
        logic       wb_sel;
        logic       halted;
        logic       bus_err;
    } ctl_t;

    typedef struct {
        ctl_t        ctl;
        state_e      st;
        logic [15:0] ret;
    } exp_t;

    logic        clk;
    logic        rst_f;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  stat;
    logic        mem_ack;
    logic        mem_req, mm_we, ir_load, pc_write, pc_sel, br_sel;
    logic [1:0]  alu_op;
    logic        rf_we, wb_sel, halted, bus_err;
    logic [15:0] retired;

    exp_t        sb[$];
    logic [15:0] exp_ret;
    int          n_cmp;
    int          n_err;

    ctl_t c_idle, c_fwait, c_fack, c_ximm, c_xrr, c_mlod, c_mstr;
    ctl_t c_wrf, c_wlod, c_babs, c_brel, c_herr, c_hhlt;

    sisc_ctrl_unit #(
        .OP_W     (4),
        .FLAG_W   (4),
        .ALU_OP_W (2),
        .CNT_W    (16),
        .MEM_TMO  (MEM_TMO),
        .AM_IMM   (8)
    ) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mm_we    (mm_we),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .alu_op   (alu_op),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .halted   (halted),
        .bus_err  (bus_err),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t mk(input logic rq, input logic we, input logic il,
                                input logic pw, input logic ps, input logic bs,
                                input logic [1:0] ao, input logic rw, input logic ws,
                                input logic h, input logic be);
        ctl_t c;
        c = {rq, we, il, pw, ps, bs, ao, rw, ws, h, be};
        return c;
    endfunction

    // Pop the oldest expectation and compare it against the live DUT outputs.
    task automatic check(input string tag);
        exp_t e;
        ctl_t o;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        o = {mem_req, mm_we, ir_load, pc_write, pc_sel, br_sel, alu_op, rf_we, wb_sel, halted, bus_err};
        n_cmp++;
        assert (o === e.ctl) else begin
            n_err++;
            $error("FAIL %s ctl: observed=%h expected=%h", tag, o, e.ctl);
        end
        n_cmp++;
        assert (dut.state === e.st) else begin
            n_err++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, dut.state, e.st);
        end
        n_cmp++;
        assert (retired === e.ret) else begin
            n_err++;
            $error("FAIL %s retired: observed=%0d expected=%0d", tag, retired, e.ret);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, record the expectation, then check.
    task automatic step(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                        input logic ack, input ctl_t ec, input state_e es, input string tag);
        @(negedge clk);
        opcode  = op;
        mm      = m;
        stat    = s;
        mem_ack = ack;
        sb.push_back('{ec, es, exp_ret});
        #1;
        check(tag);
    endtask

    // Assert reset, check it takes effect immediately and across a clock edge, then release.
    task automatic do_reset(input string tag);
        rst_f   = 1'b0;
        mem_ack = 1'b0;
        exp_ret = '0;
        #1;
        sb.push_back('{c_idle, ST_START1, exp_ret});
        check({tag, ":async"});
        @(posedge clk);
        #1;
        sb.push_back('{c_idle, ST_START1, exp_ret});
        check({tag, ":held"});
        #1;
        rst_f = 1'b1;
    endtask

    // One full instruction with configurable fetch and memory wait cycles.
    task automatic instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                         input int fw, input int mw, input ctl_t d_e, input ctl_t x_e,
                         input ctl_t m_e, input ctl_t w_e, input string tag);
        step(op, m, s, 1'b0, c_idle, ST_START1, {tag, ":start1"});
        for (int i = 0; i < fw; i++) step(op, m, s, 1'b0, c_fwait, ST_FETCH, {tag, ":fwait"});
        step(op, m, s, 1'b1, c_fack, ST_FETCH, {tag, ":fack"});
        step(op, m, s, 1'b0, d_e, ST_DECODE, {tag, ":decode"});
        step(op, m, s, 1'b0, x_e, ST_EXECUTE, {tag, ":execute"});
        for (int i = 0; i < mw; i++) step(op, m, s, 1'b0, m_e, ST_MEM, {tag, ":mwait"});
        step(op, m, s, 1'b1, m_e, ST_MEM, {tag, ":mem"});
        step(op, m, s, 1'b0, w_e, ST_WRITEBACK, {tag, ":wb"});
        exp_ret = exp_ret + 16'd1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        exp_ret = '0;
        rst_f   = 1'b0;
        opcode  = OPC_NOOP;
        mm      = 4'h0;
        stat    = 4'h0;
        mem_ack = 1'b0;

        c_idle  = mk(0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0);
        c_fwait = mk(1, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0);
        c_fack  = mk(1, 0, 1, 1, 0, 0, 2'd2, 0, 0, 0, 0);
        c_ximm  = mk(0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0);
        c_xrr   = mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        c_mlod  = mk(1, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0);
        c_mstr  = mk(1, 1, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0);
        c_wrf   = mk(0, 0, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0);
        c_wlod  = mk(0, 0, 0, 0, 0, 0, 2'd2, 1, 1, 0, 0);
        c_babs  = mk(0, 0, 0, 1, 1, 0, 2'd2, 0, 0, 0, 0);
        c_brel  = mk(0, 0, 0, 1, 1, 1, 2'd2, 0, 0, 0, 0);
        c_herr  = mk(0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1, 1);
        c_hhlt  = mk(0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1, 0);

        do_reset("init");

        instr(OPC_ALU, 4'd8, 4'h0, 0, 0, c_idle, c_ximm, c_idle, c_wrf,  "alu_imm");
        instr(OPC_ALU, 4'd3, 4'h0, 0, 0, c_idle, c_xrr,  c_idle, c_wrf,  "alu_rr");
        instr(OPC_LOD, 4'd0, 4'h0, 1, 2, c_idle, c_idle, c_mlod, c_wlod, "lod");
        instr(OPC_STR, 4'd0, 4'h0, 0, 0, c_idle, c_idle, c_mstr, c_idle, "str");
        instr(OPC_SWP, 4'd0, 4'h0, 0, 0, c_idle, c_idle, c_idle, c_wrf,  "swp");
        instr(OPC_BNE, 4'b0010, 4'b0001, 0, 0, c_babs, c_idle, c_idle, c_idle, "bne_taken");
        instr(OPC_BRR, 4'b0010, 4'b0000, 0, 0, c_idle, c_idle, c_idle, c_idle, "brr_not");
        instr(OPC_BRR, 4'b0010, 4'b0010, 0, 0, c_brel, c_idle, c_idle, c_idle, "brr_taken");
        instr(OPC_BRA, 4'b1000, 4'b1001, 0, 0, c_babs, c_idle, c_idle, c_idle, "bra_taken");
        instr(OPC_BNR, 4'b0100, 4'b0100, 0, 0, c_idle, c_idle, c_idle, c_idle, "bnr_not");
        instr(4'hC, 4'd8, 4'hF, 0, 0, c_idle, c_idle, c_idle, c_idle, "unknown_op");
        instr(OPC_LOD, 4'd0, 4'h0, MEM_TMO - 1, MEM_TMO - 1, c_idle, c_idle, c_mlod, c_wlod,
              "ack_at_tmo");

        // Reset while FETCH is waiting with mem_req high.
        step(OPC_ALU, 4'd8, 4'h0, 1'b0, c_idle, ST_START1, "midrst:start1");
        step(OPC_ALU, 4'd8, 4'h0, 1'b0, c_fwait, ST_FETCH, "midrst:fetch");
        #2;
        do_reset("midrst");

        // Fetch never acknowledged: bus error and sticky halt, later acks ignored.
        step(OPC_NOOP, 4'd0, 4'h0, 1'b0, c_idle, ST_START1, "tmo:start1");
        for (int i = 0; i < MEM_TMO; i++) step(OPC_NOOP, 4'd0, 4'h0, 1'b0, c_fwait, ST_FETCH, "tmo:fwait");
        for (int i = 0; i < 3; i++) step(OPC_NOOP, 4'd0, 4'h0, 1'b1, c_herr, ST_HALT, "tmo:halt");

        @(posedge clk);
        #1;
        do_reset("after_tmo");

        // HLT opcode halts cleanly and stays silent.
        step(OPC_HLT, 4'd0, 4'h0, 1'b0, c_idle, ST_START1, "hlt:start1");
        step(OPC_HLT, 4'd0, 4'h0, 1'b1, c_fack, ST_FETCH, "hlt:fack");
        step(OPC_HLT, 4'd0, 4'h0, 1'b0, c_idle, ST_DECODE, "hlt:decode");
        for (int i = 0; i < 20; i++) begin
            step(OPC_HLT, 4'd8, 4'hF, 1'(i % 2), c_hhlt, ST_HALT, "hlt:halt");
        end

        @(posedge clk);
        #1;
        do_reset("after_hlt");
        instr(OPC_ALU, 4'd8, 4'h0, 0, 0, c_idle, c_ximm, c_idle, c_wrf, "restart");
        step(OPC_NOOP, 4'd0, 4'h0, 1'b0, c_idle, ST_START1, "restart:start1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
